cdb_arbiter: RTL and testbench

- Common Data Bus arbiter for the out-of-order OTTER core.
- Collects completed results (RS tag + 32-bit value) from the functional units and buffers them in a small per-unit FIFO.
- Grants one result per cycle with round-robin priority and broadcasts it on the registered CDB.
- The CDB tag/value feed the map table, the reservation stations and the register-file write path.

---
 rtl/cdb_arbiter.sv | 146 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Common Data Bus arbiter. Buffers completed FU results in small
//               per-unit FIFOs and broadcasts one per cycle on a registered
//               CDB, choosing among non-empty FIFOs in round-robin order.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
  parameter int                NUM_FU      = 4,
  parameter int                TAG_W       = 4,
  parameter int                QDEPTH      = 2,
  parameter logic [TAG_W-1:0]  INVALID_TAG = 4'hF
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [NUM_FU-1:0]       FU_valid,
  input  logic [NUM_FU*TAG_W-1:0] FU_tag,
  input  logic [NUM_FU*32-1:0]    FU_val,
  output logic [NUM_FU-1:0]       FU_ready,
  output logic                    CDB_valid,
  output logic [TAG_W-1:0]        CDB_tag,
  output logic [31:0]             CDB_val,
  output logic [NUM_FU-1:0]       CDB_src
);

  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int RR_W  = $clog2(NUM_FU);

  localparam logic [CNT_W-1:0] C_FULL     = CNT_W'(QDEPTH);
  localparam logic [PTR_W-1:0] C_PTR_LAST = PTR_W'(QDEPTH - 1);
  localparam logic [RR_W-1:0]  C_RR_LAST  = RR_W'(NUM_FU - 1);

  logic [TAG_W-1:0] tag_mem [NUM_FU][QDEPTH];
  logic [31:0]      val_mem [NUM_FU][QDEPTH];
  logic [CNT_W-1:0] count   [NUM_FU];
  logic [PTR_W-1:0] rd_ptr  [NUM_FU];
  logic [PTR_W-1:0] wr_ptr  [NUM_FU];
  logic [RR_W-1:0]  rr_ptr;

  logic [NUM_FU-1:0] ready;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;
  logic              grant_any;
  logic [RR_W-1:0]   grant_idx;
  logic [TAG_W-1:0]  head_tag;
  logic [31:0]       head_val;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == C_PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign FU_ready = ready;

  // Ready depends only on the registered occupancy, never on a same-cycle pop.
  // Invalid-tag handshakes complete but are not stored.
  always_comb begin
    ready = '0;
    push  = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      ready[i] = RST_N && (count[i] < C_FULL);
      push[i]  = FU_valid[i] && ready[i] &&
                 (FU_tag[i*TAG_W +: TAG_W] != INVALID_TAG);
    end
  end

  // Round-robin scan starting at rr_ptr; first non-empty FIFO wins.
  always_comb begin
    int unsigned k;
    k         = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int j = 0; j < NUM_FU; j++) begin
      k = (int'(rr_ptr) + j) % NUM_FU;
      if (!grant_any && (count[k] != '0)) begin
        grant_any = 1'b1;
        grant_idx = RR_W'(k);
      end
    end
  end

  // Head of the granted FIFO and per-FIFO pop strobes.
  always_comb begin
    head_tag = tag_mem[grant_idx][rd_ptr[grant_idx]];
    head_val = val_mem[grant_idx][rd_ptr[grant_idx]];
    pop      = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      pop[i] = grant_any && (grant_idx == RR_W'(i));
    end
  end

  // FIFO storage writes; contents need no reset since occupancy gates reads.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push[i]) begin
        tag_mem[i][wr_ptr[i]] <= FU_tag[i*TAG_W +: TAG_W];
        val_mem[i][wr_ptr[i]] <= FU_val[i*32 +: 32];
      end
    end
  end

  // FIFO bookkeeping, round-robin pointer and the registered CDB broadcast.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_FU; i++) begin
        count[i]  <= '0;
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
      end
      rr_ptr    <= '0;
      CDB_valid <= 1'b0;
      CDB_tag   <= INVALID_TAG;
      CDB_val   <= '0;
      CDB_src   <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push[i]) begin
          wr_ptr[i] <= ptr_inc(wr_ptr[i]);
        end
        if (pop[i]) begin
          rd_ptr[i] <= ptr_inc(rd_ptr[i]);
        end
        if (push[i] && !pop[i]) begin
          count[i] <= count[i] + CNT_W'(1);
        end else if (!push[i] && pop[i]) begin
          count[i] <= count[i] - CNT_W'(1);
        end
      end
      if (grant_any) begin
        rr_ptr    <= (grant_idx == C_RR_LAST) ? '0 : grant_idx + RR_W'(1);
        CDB_valid <= 1'b1;
        CDB_tag   <= head_tag;
        CDB_val   <= head_val;
        CDB_src   <= NUM_FU'(1) << grant_idx;
      end else begin
        CDB_valid <= 1'b0;
        CDB_tag   <= INVALID_TAG;
        CDB_val   <= '0;
        CDB_src   <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_arbiter
// Description : Scoreboard bench for cdb_arbiter. A queue-based reference
//               model predicts each broadcast; a negedge monitor compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

  localparam int NUM_FU = 4;
  localparam int TAG_W  = 4;
  localparam int QDEPTH = 2;
  localparam logic [TAG_W-1:0] INV = 4'hF;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NUM_FU-1:0]       fu_valid = '0;
  logic [NUM_FU*TAG_W-1:0] fu_tag = '0;
  logic [NUM_FU*32-1:0]    fu_val = '0;
  logic [NUM_FU-1:0]       fu_ready;
  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_tag;
  logic [31:0]             cdb_val;
  logic [NUM_FU-1:0]       cdb_src;

  // Reference state: one queue of {tag,val} per FU, rotating start index,
  // and the queue of predicted broadcasts.
  logic [TAG_W+32-1:0]        mq [NUM_FU][$];
  int                         rr = 0;
  logic [TAG_W+32+NUM_FU-1:0] exp_q [$];

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(
    .NUM_FU(NUM_FU), .TAG_W(TAG_W), .QDEPTH(QDEPTH), .INVALID_TAG(INV)
  ) dut (
    .CLK(clk), .RST_N(rst_n),
    .FU_valid(fu_valid), .FU_tag(fu_tag), .FU_val(fu_val),
    .FU_ready(fu_ready),
    .CDB_valid(cdb_valid), .CDB_tag(cdb_tag), .CDB_val(cdb_val),
    .CDB_src(cdb_src)
  );

  always #5 clk = ~clk;

  // Reference model step at each rising edge.
  task automatic model_step();
    logic [NUM_FU-1:0] rdy;
    logic [TAG_W+32-1:0] e;
    int g;
    if (!rst_n) begin
      for (int i = 0; i < NUM_FU; i++) mq[i].delete();
      rr = 0;
      exp_q.delete();
      return;
    end
    for (int i = 0; i < NUM_FU; i++) rdy[i] = (mq[i].size() < QDEPTH);
    g = -1;
    for (int j = 0; j < NUM_FU; j++) begin
      if (g < 0 && mq[(rr + j) % NUM_FU].size() > 0) g = (rr + j) % NUM_FU;
    end
    if (g >= 0) begin
      e = mq[g].pop_front();
      exp_q.push_back({e, NUM_FU'(1 << g)});
      rr = (g + 1) % NUM_FU;
    end
    for (int i = 0; i < NUM_FU; i++) begin
      if (fu_valid[i] && rdy[i] && fu_tag[i*TAG_W +: TAG_W] != INV)
        mq[i].push_back({fu_tag[i*TAG_W +: TAG_W], fu_val[i*32 +: 32]});
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor: compares ready and the CDB against the model half a cycle later.
  initial forever begin
    logic [NUM_FU-1:0] exp_rdy;
    logic [TAG_W+32+NUM_FU-1:0] x;
    @(negedge clk);
    for (int i = 0; i < NUM_FU; i++)
      exp_rdy[i] = rst_n && (mq[i].size() < QDEPTH);
    checks++;
    if (fu_ready !== exp_rdy) begin
      errors++;
      $display("FAIL ready t=%0t got=%b exp=%b", $time, fu_ready, exp_rdy);
    end
    if (cdb_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious t=%0t got tag=%h val=%h src=%b exp=none",
                 $time, cdb_tag, cdb_val, cdb_src);
      end else begin
        x = exp_q.pop_front();
        if ({cdb_tag, cdb_val, cdb_src} !== x) begin
          errors++;
          $display("FAIL bcast t=%0t got tag=%h val=%h src=%b exp tag=%h val=%h src=%b",
                   $time, cdb_tag, cdb_val, cdb_src,
                   x[TAG_W+32+NUM_FU-1 -: TAG_W], x[32+NUM_FU-1 -: 32], x[NUM_FU-1:0]);
        end
      end
    end else begin
      checks++;
      if (cdb_valid !== 1'b0 || cdb_tag !== INV || cdb_val !== 32'd0 ||
          cdb_src !== '0 || exp_q.size() != 0) begin
        errors++;
        $display("FAIL idle t=%0t got v=%b tag=%h val=%h src=%b pending=%0d exp v=0 tag=f val=0 src=0 pending=0",
                 $time, cdb_valid, cdb_tag, cdb_val, cdb_src, exp_q.size());
        exp_q.delete();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fu(input int i, input logic v, input logic [TAG_W-1:0] t,
                        input logic [31:0] d);
    fu_valid[i]            = v;
    fu_tag[i*TAG_W +: TAG_W] = t;
    fu_val[i*32 +: 32]     = d;
  endtask

  task automatic clear_fu();
    fu_valid = '0;
    fu_tag   = '0;
    fu_val   = '0;
  endtask

  initial begin
    int idx;
    logic hs1;
    logic [TAG_W-1:0] bp_tags [3];
    logic [TAG_W-1:0] rt;
    bit drained;
    bp_tags[0] = 4'd4; bp_tags[1] = 4'd5; bp_tags[2] = 4'd6;

    // Reset held two edges, then idle.
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Single result from FU2.
    set_fu(2, 1'b1, 4'd3, 32'hDEADBEEF);
    tick();
    clear_fu();
    repeat (3) tick();

    // Simultaneous bursts from all FUs, twice.
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < NUM_FU; i++) set_fu(i, 1'b1, TAG_W'(i + 8*b), 32'(10 + i));
      tick();
      clear_fu();
      repeat (5) tick();
    end

    // Backpressure: FU1 holds 4,5,6 until accepted while FU0 streams.
    idx = 0;
    for (int c = 0; c < 40 && idx < 3; c++) begin
      set_fu(0, 1'b1, TAG_W'($urandom_range(0, 14)), $urandom);
      set_fu(1, 1'b1, bp_tags[idx], 32'(100 + idx));
      hs1 = fu_ready[1];
      tick();
      if (hs1) idx++;
    end
    checks++;
    if (idx != 3) begin
      errors++;
      $display("FAIL bp_accept got=%0d exp=3", idx);
    end
    clear_fu();
    repeat (6) tick();

    // Invalid-tag handshake from FU3.
    set_fu(3, 1'b1, INV, 32'd99);
    tick();
    clear_fu();
    repeat (3) tick();

    // Reset while FU0 and FU2 have queued results.
    for (int c = 0; c < 2; c++) begin
      set_fu(0, 1'b1, TAG_W'(c + 1), $urandom);
      set_fu(2, 1'b1, TAG_W'(c + 7), $urandom);
      tick();
    end
    clear_fu();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < NUM_FU; i++) begin
        rt = TAG_W'($urandom_range(0, 15));
        set_fu(i, ($urandom_range(0, 99) < 45), rt, $urandom);
      end
      rst_n = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst_n = 1'b1;
    clear_fu();

    // Drain with a bounded wait.
    drained = 1'b0;
    for (int c = 0; c < 30 && !drained; c++) begin
      tick();
      drained = 1'b1;
      for (int i = 0; i < NUM_FU; i++) if (mq[i].size() != 0) drained = 1'b0;
      if (exp_q.size() != 0) drained = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (!drained) begin
      errors++;
      $display("FAIL drain got=not_empty exp=empty");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
